nap_countdown: RTL and testbench

- Downstream stage of the time-setting FSM.
- Captures the BCD nap duration (HH:MM:SS) when the setter pulses complete, then counts it down once per second. Supports pause and cancel.
- Raises and holds an alarm when the count reaches 00:00:00, until acknowledged.
- Its remaining-time digits drive the display mux and its alarm drives the buzzer driver.

---
 rtl/nap_countdown.sv | 199 +++++++++++++++++++
 tb/tb_nap_countdown.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nap_countdown.sv
// Nap countdown timer: captures a BCD HH:MM:SS duration, counts it down once per tick and
// raises a buzzing alarm at zero. Define NAP_SNOOZE_EN to add the snooze input and snooze_cnt output.
module nap_countdown #(
    parameter int TICK_DIV = 50000000,
    parameter int BUZZ_DIV = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] hour10,
    input  logic [3:0] hour1,
    input  logic [3:0] minute10,
    input  logic [3:0] minute1,
    input  logic [3:0] second10,
    input  logic [3:0] second1,
    input  logic       pause,
    input  logic       cancel,
    input  logic       ack,
    output logic [3:0] rHour10,
    output logic [3:0] rHour1,
    output logic [3:0] rMinute10,
    output logic [3:0] rMinute1,
    output logic [3:0] rSecond10,
    output logic [3:0] rSecond1,
    output logic       running,
    output logic       alarm,
    output logic       buzz
`ifdef NAP_SNOOZE_EN
    ,
    input  logic       snooze,
    output logic [1:0] snooze_cnt
`endif
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BUZZ_DIV > 2) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        state_q, state_d;
    logic [23:0]   time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          buzz_q, buzz_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;
`ifdef NAP_SNOOZE_EN
    logic [1:0]    snzCnt_q, snzCnt_d;
`endif

    logic [23:0]   sanTime;
    logic [23:0]   decTime;
    logic          loadOk;

    function automatic logic [3:0] clampDigit(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    // Borrow ripples upward from second1; digits 1 and 3 are the tens of minutes/seconds.
    function automatic logic [23:0] decBcd(input logic [23:0] t);
        logic [23:0] r;
        logic        borrow;
        logic [3:0]  d;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = r[i*4 +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

    assign sanTime = {clampDigit(hour10, 4'd9), clampDigit(hour1, 4'd9),
                      clampDigit(minute10, 4'd5), clampDigit(minute1, 4'd9),
                      clampDigit(second10, 4'd5), clampDigit(second1, 4'd9)};
    assign loadOk  = load && (sanTime != '0);
    assign decTime = decBcd(time_q);

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        presc_d  = presc_q;
        bcnt_d   = bcnt_q;
        buzz_d   = buzz_q;
`ifdef NAP_SNOOZE_EN
        snzCnt_d = snzCnt_q;
`endif
        if (cancel) begin
            state_d  = IDLE;
            time_d   = '0;
            presc_d  = '0;
            bcnt_d   = '0;
            buzz_d   = 1'b0;
`ifdef NAP_SNOOZE_EN
            snzCnt_d = 2'd0;
`endif
        end else if (loadOk && state_q != ALARM) begin
            state_d  = RUN;
            time_d   = sanTime;
            presc_d  = '0;
`ifdef NAP_SNOOZE_EN
            snzCnt_d = 2'd0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    // The counting edge still advances the prescaler even when pause is seen.
                    if (presc_q == TICK_LAST) begin
                        presc_d = '0;
                        time_d  = decTime;
                        if (decTime == '0) begin
                            state_d = ALARM;
                            bcnt_d  = '0;
                            buzz_d  = 1'b0;
                        end else begin
                            state_d = pause ? PAUSE : RUN;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                        state_d = pause ? PAUSE : RUN;
                    end
                end
                PAUSE: begin
                    if (!pause) state_d = RUN;
                end
                ALARM: begin
`ifdef NAP_SNOOZE_EN
                    if (snooze && snzCnt_q != 2'd3) begin
                        state_d  = RUN;
                        time_d   = 24'h000500;
                        presc_d  = '0;
                        bcnt_d   = '0;
                        buzz_d   = 1'b0;
                        snzCnt_d = snzCnt_q + 2'd1;
                    end else
`endif
                    if (ack) begin
                        state_d = IDLE;
                        bcnt_d  = '0;
                        buzz_d  = 1'b0;
                    end else if (bcnt_q == BUZZ_LAST) begin
                        bcnt_d = '0;
                        buzz_d = ~buzz_q;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == RUN) || (state_d == PAUSE);
        alarm_d   = (state_d == ALARM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            time_q    <= '0;
            presc_q   <= '0;
            bcnt_q    <= '0;
            buzz_q    <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
`ifdef NAP_SNOOZE_EN
            snzCnt_q  <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            bcnt_q    <= bcnt_d;
            buzz_q    <= buzz_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
`ifdef NAP_SNOOZE_EN
            snzCnt_q  <= snzCnt_d;
`endif
        end
    end

    assign {rHour10, rHour1, rMinute10, rMinute1, rSecond10, rSecond1} = time_q;
    assign running = running_q;
    assign alarm   = alarm_q;
    assign buzz    = buzz_q;
`ifdef NAP_SNOOZE_EN
    assign snooze_cnt = snzCnt_q;
`endif

endmodule

// File: tb/tb_nap_countdown.sv
// Testbench for nap_countdown: directed steps plus a random phase, checked every cycle
// against a model that tracks the remaining time as a plain count of seconds.
module tb_nap_countdown;

    localparam int TICK = 4;
    localparam int BUZZ = 2;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_ALARM = 3;
`ifdef NAP_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic load = 1'b0, pause = 1'b0, cancel = 1'b0, ack = 1'b0;
    logic [3:0] hour10 = 4'h0, hour1 = 4'h0, minute10 = 4'h0;
    logic [3:0] minute1 = 4'h0, second10 = 4'h0, second1 = 4'h0;
    logic [3:0] rHour10, rHour1, rMinute10, rMinute1, rSecond10, rSecond1;
    logic running, alarm, buzz;
`ifdef NAP_SNOOZE_EN
    logic snooze = 1'b0;
    logic [1:0] snooze_cnt;
`endif
    logic [23:0] rNow;

    int testCount = 0;
    int failCount = 0;
    int mState, mSecs, mPresc, mBuzzCnt, mBuzz, mSnz;
    logic pauseLvl = 1'b0;

    nap_countdown #(.TICK_DIV(TICK), .BUZZ_DIV(BUZZ)) dut (
        .clock(clock), .reset(reset), .load(load),
        .hour10(hour10), .hour1(hour1), .minute10(minute10),
        .minute1(minute1), .second10(second10), .second1(second1),
        .pause(pause), .cancel(cancel), .ack(ack),
        .rHour10(rHour10), .rHour1(rHour1), .rMinute10(rMinute10),
        .rMinute1(rMinute1), .rSecond10(rSecond10), .rSecond1(rSecond1),
        .running(running), .alarm(alarm), .buzz(buzz)
`ifdef NAP_SNOOZE_EN
        , .snooze(snooze), .snooze_cnt(snooze_cnt)
`endif
    );

    assign rNow = {rHour10, rHour1, rMinute10, rMinute1, rSecond10, rSecond1};

    always #5 clock = ~clock;

    // Duration in seconds after clamping each digit to its legal maximum.
    function automatic int satSecs(input logic [23:0] d);
        int h10, h1, m10, m1, s10, s1;
        h10 = (d[23:20] > 4'd9) ? 9 : int'(d[23:20]);
        h1  = (d[19:16] > 4'd9) ? 9 : int'(d[19:16]);
        m10 = (d[15:12] > 4'd5) ? 5 : int'(d[15:12]);
        m1  = (d[11:8]  > 4'd9) ? 9 : int'(d[11:8]);
        s10 = (d[7:4]   > 4'd5) ? 5 : int'(d[7:4]);
        s1  = (d[3:0]   > 4'd9) ? 9 : int'(d[3:0]);
        return (h10 * 10 + h1) * 3600 + (m10 * 10 + m1) * 60 + s10 * 10 + s1;
    endfunction

    function automatic logic [23:0] secsToBcd(input int s);
        int h, m, sec;
        h   = s / 3600;
        m   = (s / 60) % 60;
        sec = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    function automatic void modelReset();
        mState = S_IDLE; mSecs = 0; mPresc = 0; mBuzzCnt = 0; mBuzz = 0; mSnz = 0;
    endfunction

    // One clock edge of the reference behaviour, given the inputs seen at that edge.
    function automatic void modelStep(input logic ld, input logic [23:0] dig, input logic ps,
                                      input logic cn, input logic ak, input logic sz);
        int total;
        total = satSecs(dig);
        if (cn) begin
            modelReset();
        end else if (ld && mState != S_ALARM && total != 0) begin
            mState = S_RUN; mSecs = total; mPresc = 0; mSnz = 0;
        end else if (mState == S_RUN) begin
            mPresc = (mPresc + 1) % TICK;
            if (mPresc == 0) mSecs = mSecs - 1;
            if (mSecs == 0) begin
                mState = S_ALARM; mBuzzCnt = 0; mBuzz = 0;
            end else begin
                mState = ps ? S_PAUSE : S_RUN;
            end
        end else if (mState == S_PAUSE) begin
            if (!ps) mState = S_RUN;
        end else if (mState == S_ALARM) begin
            if (SNZ_EN && sz && mSnz < 3) begin
                mState = S_RUN; mSecs = 300; mPresc = 0; mBuzzCnt = 0; mBuzz = 0; mSnz++;
            end else if (ak) begin
                mState = S_IDLE; mBuzzCnt = 0; mBuzz = 0;
            end else begin
                mBuzzCnt = (mBuzzCnt + 1) % BUZZ;
                if (mBuzzCnt == 0) mBuzz = 1 - mBuzz;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, " r"}, {8'h0, rNow}, {8'h0, secsToBcd(mSecs)});
        checkOutput({where, " running"}, 32'(running), 32'(mState == S_RUN || mState == S_PAUSE));
        checkOutput({where, " alarm"}, 32'(alarm), 32'(mState == S_ALARM));
        checkOutput({where, " buzz"}, 32'(buzz), 32'(mBuzz));
`ifdef NAP_SNOOZE_EN
        checkOutput({where, " snooze_cnt"}, 32'(snooze_cnt), 32'(mSnz));
`endif
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check just after it.
    task automatic applyStimulus(input logic ld, input logic [23:0] dig, input logic cn,
                                 input logic ak, input logic sz, input string tag);
        load = ld;
        {hour10, hour1, minute10, minute1, second10, second1} = dig;
        pause = pauseLvl;
        cancel = cn;
        ack = ak;
`ifdef NAP_SNOOZE_EN
        snooze = sz;
`endif
        @(posedge clock);
        modelStep(ld, dig, pauseLvl, cn, ak, sz);
        #1;
        checkAll(tag);
        load = 1'b0; cancel = 1'b0; ack = 1'b0;
`ifdef NAP_SNOOZE_EN
        snooze = 1'b0;
`endif
    endtask

    task automatic idleCycles(input int n, input string tag);
        repeat (n) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic ld, cn, ak, sz;
        logic [23:0] dig;

        // Reset asserted mid-cycle before any edge; outputs must clear asynchronously.
        modelReset();
        #2 reset = 1'b0;
        #1 checkAll("reset async");
        @(posedge clock);
        @(posedge clock);
        #1 checkAll("reset held");
        reset = 1'b1;

        // Basic countdown from 00:00:03 into the alarm, then acknowledge.
        applyStimulus(1'b1, 24'h000003, 1'b0, 1'b0, 1'b0, "load3");
        checkOutput("running after load", 32'(running), 32'd1);
        idleCycles(12, "count3");
        checkOutput("alarm at zero", 32'(alarm), 32'd1);
        checkOutput("r at zero", {8'h0, rNow}, 32'h0);
        idleCycles(7, "buzzing");
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, "ack");
        checkOutput("alarm after ack", 32'(alarm), 32'd0);
        checkOutput("buzz after ack", 32'(buzz), 32'd0);

        // Borrow chain through every digit, then a restart while running.
        applyStimulus(1'b1, 24'h100000, 1'b0, 1'b0, 1'b0, "load 10h");
        idleCycles(4, "borrow h");
        checkOutput("borrow hours", {8'h0, rNow}, 32'h095959);
        applyStimulus(1'b1, 24'h001000, 1'b0, 1'b0, 1'b0, "load 10m");
        idleCycles(4, "borrow m");
        checkOutput("borrow minutes", {8'h0, rNow}, 32'h000959);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b0, "cancel");

        // Over-range digits clamp; an all-zero load is ignored.
        applyStimulus(1'b1, 24'hC0700F, 1'b0, 1'b0, 1'b0, "sanitise");
        checkOutput("sanitised", {8'h0, rNow}, 32'h905009);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b0, "cancel");
        applyStimulus(1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, "zero load");
        checkOutput("zero load running", 32'(running), 32'd0);

        // Pause after two prescaler counts; the partial second survives the pause.
        applyStimulus(1'b1, 24'h000010, 1'b0, 1'b0, 1'b0, "load 10s");
        idleCycles(2, "pre-pause");
        pauseLvl = 1'b1;
        idleCycles(20, "paused");
        checkOutput("frozen", {8'h0, rNow}, 32'h000010);
        pauseLvl = 1'b0;
        idleCycles(1, "release");
        checkOutput("release no tick", {8'h0, rNow}, 32'h000010);
        idleCycles(1, "release tick");
        checkOutput("first tick after release", {8'h0, rNow}, 32'h000009);
        idleCycles(3, "run");
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b0, "cancel in run");
        checkOutput("cancel r", {8'h0, rNow}, 32'h0);
        checkOutput("cancel running", 32'(running), 32'd0);

        // Cancel beats a simultaneous load; a load while running restarts cleanly.
        applyStimulus(1'b1, 24'h000020, 1'b0, 1'b0, 1'b0, "load 20s");
        idleCycles(2, "run");
        applyStimulus(1'b1, 24'h000030, 1'b1, 1'b0, 1'b0, "cancel+load");
        checkOutput("cancel wins r", {8'h0, rNow}, 32'h0);
        checkOutput("cancel wins running", 32'(running), 32'd0);
        applyStimulus(1'b1, 24'h000008, 1'b0, 1'b0, 1'b0, "load 8s");
        idleCycles(14, "to 5s");
        checkOutput("at 5s", {8'h0, rNow}, 32'h000005);
        applyStimulus(1'b1, 24'h000100, 1'b0, 1'b0, 1'b0, "reload 1m");
        idleCycles(3, "after reload");
        checkOutput("reload held", {8'h0, rNow}, 32'h000100);
        idleCycles(1, "reload tick");
        checkOutput("reload tick", {8'h0, rNow}, 32'h000059);

        // Asynchronous reset in the middle of a countdown.
        reset = 1'b0;
        modelReset();
        #1 checkAll("reset mid-run");
        @(posedge clock);
        #1 checkAll("reset mid-run held");
        reset = 1'b1;

`ifdef NAP_SNOOZE_EN
        // Three snoozes are honoured, the fourth is ignored.
        applyStimulus(1'b1, 24'h000001, 1'b0, 1'b0, 1'b0, "load 1s");
        idleCycles(4, "to alarm");
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, "snooze");
            checkOutput("snooze r", {8'h0, rNow}, 32'h000500);
            checkOutput("snooze cnt", 32'(snooze_cnt), 32'(k));
            idleCycles(300 * TICK, "snoozed run");
        end
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, "snooze 4");
        checkOutput("snooze 4 alarm", 32'(alarm), 32'd1);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, "ack");
`endif

        // Random mix of short loads, pause toggling, cancels, acks and snoozes.
        for (int n = 0; n < 800; n++) begin
            ld  = ($urandom_range(0, 19) == 0);
            dig = {12'h000, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 9) == 0) dig = 24'($urandom);
            if ($urandom_range(0, 15) == 0) pauseLvl = ~pauseLvl;
            cn = ($urandom_range(0, 79) == 0);
            ak = ($urandom_range(0, 11) == 0);
            sz = SNZ_EN && ($urandom_range(0, 11) == 0);
            applyStimulus(ld, dig, cn, ak, sz, "random");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
